// File: rtl/pulse_stretcher_pkg.sv
// Shared types and helpers for the pulse stretcher and its one-shot input stage.
//   t_stretch_state : stretcher FSM states (2'b11 unused).
//   t_oneshot_state : level-to-pulse FSM states.
//   cnt_width()     : down-counter width able to hold HOLD_CYCLES-1 and GAP_CYCLES-1.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HOLD = 2'b01,
    ST_GAP  = 2'b10
  } t_stretch_state;

  typedef enum logic {
    OS_LOW  = 1'b0,
    OS_HIGH = 1'b1
  } t_oneshot_state;

  // At least 2 so the counter is never zero bits wide.
  function automatic int cnt_width(input int hold_cycles, input int gap_cycles);
    int m;
    m = 2;
    if (hold_cycles > m) m = hold_cycles;
    if (gap_cycles > m) m = gap_cycles;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/one_shot_fsm.sv
// Level-to-pulse converter: emits a single registered one-clock pulse on every
// low-to-high transition of x.
// Ports:
//   clk : system clock, posedge
//   rst : synchronous reset, active-high
//   x   : level input
//   y   : registered one-clock pulse, one clock after the rising level is sampled
module one_shot_fsm
  import pulse_stretcher_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic x,
  output logic y
);

  t_oneshot_state state_reg, state_next;
  logic           pulse_next;
  logic           y_reg;

  always_comb begin
    state_next = state_reg;
    pulse_next = 1'b0;
    case (state_reg)
      OS_LOW: begin
        if (x) begin
          state_next = OS_HIGH;
          pulse_next = 1'b1;
        end
      end
      OS_HIGH: begin
        // Stay armed-off until the level drops, so a held level fires once.
        if (!x) state_next = OS_LOW;
      end
      default: state_next = OS_LOW;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= OS_LOW;
      y_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      y_reg     <= pulse_next;
    end
  end

  assign y = y_reg;

endmodule

// File: rtl/pulse_stretcher_fsm.sv
// Pulse stretcher: turns single-cycle events into a level held for HOLD_CYCLES
// clocks, followed by at least GAP_CYCLES low clocks before the next level.
// Parameters:
//   HOLD_CYCLES : clocks y stays high per accepted event (>= 1)
//   GAP_CYCLES  : minimum low clocks between levels (0 = no gap)
//   RETRIGGER   : 1 = event during hold restarts it; 0 = one-deep queue
//   LEVEL_IN    : 1 = x is a level, converted to a pulse by one_shot_fsm
// Ports:
//   clk     : system clock, posedge
//   rst     : synchronous reset, active-high
//   x       : event input (pulse, or level when LEVEL_IN=1)
//   y       : registered stretched level
//   busy    : registered; high while not idle or an event is queued
//   dropped : registered one-clock pulse when an event is discarded
module pulse_stretcher_fsm
  import pulse_stretcher_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int RETRIGGER   = 0,
  parameter int LEVEL_IN    = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic x,
  output logic y,
  output logic busy,
  output logic dropped
);

  localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  generate
    if (HOLD_CYCLES < 1) begin : g_hold_check
      $error("pulse_stretcher_fsm: HOLD_CYCLES must be >= 1");
    end
    if (GAP_CYCLES < 0) begin : g_gap_check
      $error("pulse_stretcher_fsm: GAP_CYCLES must be >= 0");
    end
  endgenerate

  // Event source: raw pulse, or a level reduced to its rising-edge pulse.
  logic ev;

  generate
    if (LEVEL_IN != 0) begin : g_level_in
      one_shot_fsm u_one_shot (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .y   (ev)
      );
    end else begin : g_pulse_in
      assign ev = x;
    end
  endgenerate

  t_stretch_state  state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            pending_reg, pending_next;
  logic            drop_next;
  logic            y_reg, busy_reg, dropped_reg;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    pending_next = pending_reg;
    drop_next    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (ev) begin
          state_next = ST_HOLD;
          cnt_next   = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if ((RETRIGGER != 0) && ev) begin
          cnt_next = HOLD_LOAD;
        end else begin
          // Queue the event (only reachable with RETRIGGER=0 when ev is high).
          if (ev) begin
            if (pending_reg) drop_next = 1'b1;
            else             pending_next = 1'b1;
          end
          if (cnt_reg == '0) begin
            if (GAP_CYCLES > 0) begin
              state_next = ST_GAP;
              cnt_next   = GAP_LOAD;
            end else if (pending_reg || ev) begin
              // No gap: service the queued event immediately. An event on the
              // same edge merges into this service rather than being dropped.
              cnt_next     = HOLD_LOAD;
              pending_next = 1'b0;
              drop_next    = 1'b0;
            end else begin
              state_next = ST_IDLE;
            end
          end else begin
            cnt_next = cnt_reg - CNT_ONE;
          end
        end
      end
      ST_GAP: begin
        if (cnt_reg == '0) begin
          // Last gap clock: a simultaneous event merges into the service.
          if (pending_reg || ev) begin
            state_next   = ST_HOLD;
            cnt_next     = HOLD_LOAD;
            pending_next = 1'b0;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
          if (ev) begin
            if (pending_reg) drop_next = 1'b1;
            else             pending_next = 1'b1;
          end
        end
      end
      default: begin
        state_next   = ST_IDLE;
        cnt_next     = '0;
        pending_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      pending_reg <= 1'b0;
      y_reg       <= 1'b0;
      busy_reg    <= 1'b0;
      dropped_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      pending_reg <= pending_next;
      // Outputs are registered from the current state, so y trails it by one clock.
      y_reg       <= (state_reg == ST_HOLD);
      busy_reg    <= (state_reg != ST_IDLE) || pending_reg;
      dropped_reg <= drop_next;
    end
  end

  assign y       = y_reg;
  assign busy    = busy_reg;
  assign dropped = dropped_reg;

endmodule

// File: tb/tb_pulse_stretcher_fsm.sv
// Self-checking bench for pulse_stretcher_fsm. Five instances with different
// parameter sets share clk, rst and x; directed scenarios check the relevant
// instance against hand-derived waveforms, and a randomized run checks every
// instance against an interval-based reference model.
module tb_pulse_stretcher_fsm;

  localparam int ND = 5;
  localparam int CFG_H  [ND] = '{4, 4, 4, 3, 1};
  localparam int CFG_G  [ND] = '{2, 2, 2, 0, 1};
  localparam int CFG_RT [ND] = '{0, 1, 0, 0, 0};
  localparam int CFG_LV [ND] = '{0, 0, 1, 0, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic x   = 1'b0;
  logic [ND-1:0] y_w, busy_w, drop_w;

  int checks = 0;
  int errors = 0;

  logic [63:0] rec_y [ND];
  logic [63:0] rec_b [ND];
  logic [63:0] rec_d [ND];

  pulse_stretcher_fsm u_def (
    .clk(clk), .rst(rst), .x(x), .y(y_w[0]), .busy(busy_w[0]), .dropped(drop_w[0]));

  pulse_stretcher_fsm #(.RETRIGGER(1)) u_rt (
    .clk(clk), .rst(rst), .x(x), .y(y_w[1]), .busy(busy_w[1]), .dropped(drop_w[1]));

  pulse_stretcher_fsm #(.LEVEL_IN(1)) u_lv (
    .clk(clk), .rst(rst), .x(x), .y(y_w[2]), .busy(busy_w[2]), .dropped(drop_w[2]));

  pulse_stretcher_fsm #(.HOLD_CYCLES(3), .GAP_CYCLES(0)) u_g0 (
    .clk(clk), .rst(rst), .x(x), .y(y_w[3]), .busy(busy_w[3]), .dropped(drop_w[3]));

  pulse_stretcher_fsm #(.HOLD_CYCLES(1), .GAP_CYCLES(1)) u_h1 (
    .clk(clk), .rst(rst), .x(x), .y(y_w[4]), .busy(busy_w[4]), .dropped(drop_w[4]));

  // Edge 0 is a reset edge; x bit e is sampled at edge e; outputs after edge e
  // are recorded at index e. rst_at > 0 reasserts reset on that edge.
  task automatic run_seq(input int n, input logic [63:0] xpat, input int rst_at);
    rst = 1'b1;
    x   = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int d = 0; d < ND; d++) begin
      rec_y[d] = '0; rec_b[d] = '0; rec_d[d] = '0;
      rec_y[d][0] = y_w[d]; rec_b[d][0] = busy_w[d]; rec_d[d][0] = drop_w[d];
    end
    for (int e = 1; e <= n; e++) begin
      x   = xpat[e];
      rst = (e == rst_at);
      @(posedge clk);
      #1;
      for (int d = 0; d < ND; d++) begin
        rec_y[d][e] = y_w[d];
        rec_b[d][e] = busy_w[d];
        rec_d[d][e] = drop_w[d];
      end
    end
    x   = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] p;
    p = '0;
    run_seq(4, p, 0);
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (rec_y[d][0] !== 1'b0 || rec_b[d][0] !== 1'b0 || rec_d[d][0] !== 1'b0) begin
        errors++;
        $display("FAIL reset dut%0d y/busy/dropped got %b%b%b want 000",
                 d, rec_y[d][0], rec_b[d][0], rec_d[d][0]);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    logic [63:0] p;
    logic exp;
    p = '0;
    p[10] = 1'b1;
    run_seq(22, p, 0);
    for (int e = 1; e <= 22; e++) begin
      exp = (e >= 11 && e <= 14);
      checks++;
      if (rec_y[0][e] !== exp) begin
        errors++;
        $display("FAIL single_y edge %0d got %b want %b", e, rec_y[0][e], exp);
      end
      checks++;
      if (rec_d[0][e] !== 1'b0) begin
        errors++;
        $display("FAIL single_dropped edge %0d got %b want 0", e, rec_d[0][e]);
      end
    end
    checks++;
    if (rec_b[0][16] !== 1'b1 || rec_b[0][17] !== 1'b0) begin
      errors++;
      $display("FAIL single_busy edges 16/17 got %b%b want 10", rec_b[0][16], rec_b[0][17]);
    end
    $display("test_single done");
  endtask

  task automatic test_back_to_back();
    logic [63:0] p;
    logic exp;
    p = '0;
    p[10] = 1'b1;
    p[12] = 1'b1;
    run_seq(26, p, 0);
    for (int e = 1; e <= 26; e++) begin
      exp = (e >= 11 && e <= 14) || (e >= 17 && e <= 20);
      checks++;
      if (rec_y[0][e] !== exp) begin
        errors++;
        $display("FAIL b2b_y edge %0d got %b want %b", e, rec_y[0][e], exp);
      end
      checks++;
      if (rec_d[0][e] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_dropped edge %0d got %b want 0", e, rec_d[0][e]);
      end
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_drop();
    logic [63:0] p;
    logic exp;
    p = '0;
    p[10] = 1'b1;
    p[12] = 1'b1;
    p[13] = 1'b1;
    run_seq(30, p, 0);
    for (int e = 1; e <= 30; e++) begin
      exp = (e >= 11 && e <= 14) || (e >= 17 && e <= 20);
      checks++;
      if (rec_y[0][e] !== exp) begin
        errors++;
        $display("FAIL drop_y edge %0d got %b want %b", e, rec_y[0][e], exp);
      end
      exp = (e == 13);
      checks++;
      if (rec_d[0][e] !== exp) begin
        errors++;
        $display("FAIL drop_dropped edge %0d got %b want %b", e, rec_d[0][e], exp);
      end
    end
    $display("test_drop done");
  endtask

  task automatic test_retrigger();
    logic [63:0] p;
    logic exp;
    p = '0;
    p[10] = 1'b1;
    p[13] = 1'b1;
    run_seq(24, p, 0);
    for (int e = 1; e <= 24; e++) begin
      exp = (e >= 11 && e <= 17);
      checks++;
      if (rec_y[1][e] !== exp) begin
        errors++;
        $display("FAIL retrigger_y edge %0d got %b want %b", e, rec_y[1][e], exp);
      end
    end
    $display("test_retrigger done");
  endtask

  task automatic test_level();
    logic [63:0] p;
    logic exp;
    p = '0;
    for (int e = 10; e <= 29; e++) p[e] = 1'b1;
    run_seq(40, p, 0);
    for (int e = 1; e <= 40; e++) begin
      exp = (e >= 12 && e <= 15);
      checks++;
      if (rec_y[2][e] !== exp) begin
        errors++;
        $display("FAIL level_y edge %0d got %b want %b", e, rec_y[2][e], exp);
      end
    end
    $display("test_level done");
  endtask

  task automatic test_reset_mid_hold();
    logic [63:0] p;
    logic exp;
    p = '0;
    p[10] = 1'b1;
    p[11] = 1'b1;
    run_seq(30, p, 12);
    for (int e = 11; e <= 30; e++) begin
      exp = (e == 11);
      checks++;
      if (rec_y[0][e] !== exp) begin
        errors++;
        $display("FAIL rst_hold_y edge %0d got %b want %b", e, rec_y[0][e], exp);
      end
      checks++;
      if (rec_b[0][e] !== exp) begin
        errors++;
        $display("FAIL rst_hold_busy edge %0d got %b want %b", e, rec_b[0][e], exp);
      end
    end
    $display("test_reset_mid_hold done");
  endtask

  // Reference model: each accepted event schedules a level as an interval of
  // edges [start, hold_last] followed by a gap ending at gap_last; the phase at
  // any edge is found by comparing the previous edge number to those bounds.
  task automatic test_random();
    int  hold_last [ND];
    int  gap_last  [ND];
    bit  pend      [ND];
    bit  os_pulse  [ND];
    bit  os_prev   [ND];
    int  dens, prev, h, g;
    bit  xv, rv, ev, in_hold, in_gap, ey, eb, ed;
    int  n_ev;
    n_ev = 0;
    rst = 1'b1;
    x   = 1'b0;
    @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      hold_last[d] = -1; gap_last[d] = -1;
      pend[d] = 1'b0; os_pulse[d] = 1'b0; os_prev[d] = 1'b0;
    end
    dens = 20;
    for (int e = 1; e <= 1500; e++) begin
      if (e % 100 == 1) dens = $urandom_range(90, 3);
      xv = ($urandom_range(99, 0) < dens);
      rv = ($urandom_range(199, 0) == 0);
      if (xv) n_ev++;
      x   = xv;
      rst = rv;
      @(posedge clk);
      #1;
      for (int d = 0; d < ND; d++) begin
        h = CFG_H[d];
        g = CFG_G[d];
        if (rv) begin
          pend[d] = 1'b0;
          hold_last[d] = e - 1;
          gap_last[d]  = e - 1;
          os_pulse[d] = 1'b0;
          os_prev[d]  = 1'b0;
          ey = 1'b0; eb = 1'b0; ed = 1'b0;
        end else begin
          ev = (CFG_LV[d] != 0) ? os_pulse[d] : xv;
          os_pulse[d] = xv && !os_prev[d];
          os_prev[d]  = xv;
          prev    = e - 1;
          in_hold = (prev <= hold_last[d]);
          in_gap  = !in_hold && (prev <= gap_last[d]);
          ey = in_hold;
          eb = in_hold || in_gap || pend[d];
          ed = 1'b0;
          if (in_hold) begin
            if (CFG_RT[d] != 0 && ev) begin
              hold_last[d] = e + h - 1;
              gap_last[d]  = hold_last[d] + g;
            end else if (prev == hold_last[d] && g == 0) begin
              if (pend[d] || ev) begin
                pend[d] = 1'b0;
                hold_last[d] = e + h - 1;
                gap_last[d]  = hold_last[d];
              end
            end else if (ev) begin
              if (pend[d]) ed = 1'b1;
              else         pend[d] = 1'b1;
            end
          end else if (in_gap) begin
            if (prev == gap_last[d]) begin
              if (pend[d] || ev) begin
                pend[d] = 1'b0;
                hold_last[d] = e + h - 1;
                gap_last[d]  = hold_last[d] + g;
              end
            end else if (ev) begin
              if (pend[d]) ed = 1'b1;
              else         pend[d] = 1'b1;
            end
          end else if (ev) begin
            hold_last[d] = e + h - 1;
            gap_last[d]  = hold_last[d] + g;
          end
        end
        checks++;
        if (y_w[d] !== ey) begin
          errors++;
          $display("FAIL rand_y dut%0d edge %0d got %b want %b", d, e, y_w[d], ey);
        end
        checks++;
        if (busy_w[d] !== eb) begin
          errors++;
          $display("FAIL rand_busy dut%0d edge %0d got %b want %b", d, e, busy_w[d], eb);
        end
        checks++;
        if (drop_w[d] !== ed) begin
          errors++;
          $display("FAIL rand_dropped dut%0d edge %0d got %b want %b", d, e, drop_w[d], ed);
        end
      end
    end
    x   = 1'b0;
    rst = 1'b0;
    $display("test_random done, %0d input pulses", n_ev);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_drop();
    test_retrigger();
    test_level();
    test_reset_mid_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_stretcher_fsm.md
Name: pulse_stretcher_fsm

Overview:
Converts single-cycle event pulses into a clean output level held for a guaranteed minimum number of clocks, followed by a guaranteed minimum low gap. It is the complement of one_shot_fsm, which turns a level into a pulse; this block turns a pulse back into a level. It drives LEDs and slow-sampled status lines from strobes produced by the SPI/UART/ACL control FSMs. An optional input stage reuses one_shot_fsm so that a level input is accepted as well.

Parameters:
HOLD_CYCLES, 4, number of clocks y stays high per accepted event; must be >= 1.
GAP_CYCLES, 2, minimum number of low clocks on y between two stretched levels; 0 disables the gap.
RETRIGGER, 0, 1 = an event during HOLD reloads the hold counter; 0 = the event is queued (one-deep) and serviced after the gap.
LEVEL_IN, 0, 1 = x is a level and passes through one_shot_fsm first (adds 1 clock of latency); 0 = x is a pulse.

Ports:
clk  input  1  system clock, all logic on posedge.
rst  input  1  synchronous reset, active-high.
x  input  1  event input: pulse, or level when LEVEL_IN=1.
y  output  1  stretched level, registered.
busy  output  1  registered; high when state != ST_IDLE or the pending flag is set.
dropped  output  1  registered one-clock pulse when an event is discarded.

Behaviour:
- Reset is synchronous and active-high. On rst: state ST_IDLE, counter 0, pending 0, y 0, busy 0, dropped 0. Reset mid-HOLD forces y low on the next edge and discards any queued event.
- Let ev = x (LEVEL_IN=0) or the one_shot_fsm output (LEVEL_IN=1). ev is sampled on every posedge.
- Architecture: state register plus combinational next-state/output logic. All outputs are then registered, so y lags the state by 1 clock.
- Counter width is $clog2(max(HOLD_CYCLES, GAP_CYCLES, 2)). The counter is a down-counter loaded with N-1 on entry to a state of length N.
- ST_IDLE:
  - ev=1 -> ST_HOLD, counter = HOLD_CYCLES-1.
  - ev=0 -> stay.
- ST_HOLD (y=1):
  - RETRIGGER=1 and ev=1 -> counter = HOLD_CYCLES-1, stay.
  - RETRIGGER=0 and ev=1 -> set pending if clear; if pending is already set, pulse dropped.
  - counter==0 and no reload -> ST_GAP with counter = GAP_CYCLES-1. If GAP_CYCLES=0, go instead to ST_HOLD with a reload when (pending or ev), clearing pending; otherwise go to ST_IDLE.
  - Otherwise decrement the counter.
- ST_GAP (y=0):
  - ev=1 -> set pending; if pending is already set, pulse dropped.
  - counter==0 -> ST_HOLD with a reload if (pending or ev), clearing pending; otherwise ST_IDLE.
  - Otherwise decrement the counter.
- Simultaneous events: an ev arriving on the same edge pending is consumed merges into that service and is not counted as dropped.
- Latency: ev sampled at edge k -> y high after edge k+1, for exactly HOLD_CYCLES clocks (LEVEL_IN=1: add 1).
- Encoding 2'b11 is unreachable; the default case of the next-state logic maps it to ST_IDLE.
- Back-to-back stretched levels are separated by exactly GAP_CYCLES low clocks when an event is pending.

Decomposition:
- Shared package pulse_stretcher_pkg holds:
  - typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_GAP} t_stretch_state;
  - a function computing the counter width from HOLD_CYCLES and GAP_CYCLES.
- One sub-module: one_shot_fsm, instantiated under generate only when LEVEL_IN=1.
- The parameter legality check (HOLD_CYCLES >= 1) is an elaboration-time assertion.

Test Plan:
1. Defaults; single 1-clock x at edge 10 -> y=1 from edge 11 through edge 14 (4 clocks), low at edge 15; busy low after edge 17.
2. RETRIGGER=0; x pulses at edges 10 and 12 -> y high for 4 clocks, low for 2, high for 4 again; dropped never asserted.
3. RETRIGGER=0; x pulses at edges 10, 12, 13 -> third pulse dropped: dropped=1 for one clock after edge 13; exactly two stretched levels.
4. RETRIGGER=1; x pulses at edges 10 and 13 -> y continuously high from edge 11 through edge 17 (7 clocks), then low.
5. LEVEL_IN=1; x held high for 20 clocks from edge 10 -> single 4-clock level, y rising after edge 12; no second level while x stays high.
6. rst asserted at edge 12 during HOLD with an event pending -> y=0, busy=0 after edge 13; no further y activity until a new x.
